// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT kernel phase sequencer.
package fft_ctrl_pkg;

  localparam int unsigned WDOG_W_DEFAULT = 16;
  localparam int unsigned FCNT_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StComp,
    StStore,
    StDone,
    StHang
  } state_e;

  localparam logic [1:0] PH_NONE  = 2'b00;
  localparam logic [1:0] PH_LOAD  = 2'b01;
  localparam logic [1:0] PH_STORE = 2'b10;

endpackage

// File: rtl/fft_stall_watchdog.sv
// Saturating count of consecutive blocked cycles; trips when the run reaches limit.
module fft_stall_watchdog #(
  parameter int unsigned WDOG_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic              blk,
  input  logic [WDOG_W-1:0] limit,
  output logic              trip
);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_inc;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + WDOG_W'(1);

  always_ff @(posedge clk) begin
    if (rst || clear || !enable || !blk) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_inc;
    end
  end

  // A zero limit disables tripping entirely.
  assign trip = enable && blk && (limit != '0) && (cnt_inc >= limit);

endmodule

// File: rtl/fft_phase_sequencer.sv
// Frame sequencer for the 32-point FFT: LOAD -> COMP -> STORE under ap_ctrl_hs,
// with a stall watchdog on the streaming phases.
module fft_phase_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned WDOG_W = WDOG_W_DEFAULT,
  parameter int unsigned FCNT_W = FCNT_W_DEFAULT
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic              ld_start,
  input  logic              ld_ready,
  input  logic              ld_done,
  input  logic              ld_blk,
  output logic              cp_start,
  input  logic              cp_ready,
  input  logic              cp_done,
  output logic              st_start,
  input  logic              st_ready,
  input  logic              st_done,
  input  logic              st_blk,
  input  logic [WDOG_W-1:0] wdog_limit,
  input  logic              abort,
  output logic              hang,
  output logic [1:0]        hang_phase,
  output logic [FCNT_W-1:0] frame_cnt
);

  state_e            state_q, state_d;
  logic              started_q, started_d;
  logic [1:0]        hang_phase_q, hang_phase_d;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic              wd_en, wd_blk, wd_clear, wd_trip;

  assign wd_en    = (state_q == StLoad) || (state_q == StStore);
  assign wd_blk   = (state_q == StLoad) ? ld_blk : (state_q == StStore) ? st_blk : 1'b0;
  assign wd_clear = (state_d != state_q);

  fft_stall_watchdog #(
    .WDOG_W (WDOG_W)
  ) u_wdog (
    .clk    (ap_clk),
    .rst    (ap_rst),
    .enable (wd_en),
    .clear  (wd_clear),
    .blk    (wd_blk),
    .limit  (wdog_limit),
    .trip   (wd_trip)
  );

  always_comb begin
    state_d      = state_q;
    started_d    = started_q;
    hang_phase_d = hang_phase_q;
    unique case (state_q)
      StIdle: if (ap_start) state_d = StLoad;
      StLoad: begin
        started_d = started_q | ld_ready;
        // done outranks a watchdog trip in the same cycle
        if (ld_done) begin
          state_d = StComp;
        end else if (wd_trip) begin
          state_d      = StHang;
          hang_phase_d = PH_LOAD;
        end
      end
      StComp: begin
        started_d = started_q | cp_ready;
        if (cp_done) state_d = StStore;
      end
      StStore: begin
        started_d = started_q | st_ready;
        if (st_done) begin
          state_d = StDone;
        end else if (wd_trip) begin
          state_d      = StHang;
          hang_phase_d = PH_STORE;
        end
      end
      StDone: state_d = StIdle;
      StHang: begin
        if (abort) begin
          state_d      = StIdle;
          hang_phase_d = PH_NONE;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) started_d = 1'b0;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= StIdle;
      started_q    <= 1'b0;
      hang_phase_q <= PH_NONE;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      started_q    <= started_d;
      hang_phase_q <= hang_phase_d;
      if (state_q == StDone) frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
    end
  end

  assign ld_start   = (state_q == StLoad) && !started_q;
  assign cp_start   = (state_q == StComp) && !started_q;
  assign st_start   = (state_q == StStore) && !started_q;
  assign ap_done    = (state_q == StDone);
  assign ap_ready   = (state_q == StDone);
  assign ap_idle    = (state_q == StIdle);
  assign hang       = (state_q == StHang);
  assign hang_phase = hang_phase_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_phase_sequencer.sv
// Self-checking bench: behavioural frame model compared every cycle, plus directed literal checks.
module tb_fft_phase_sequencer;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ap_start = 1'b0;
  logic        ld_ready = 1'b0, ld_done = 1'b0, ld_blk = 1'b0;
  logic        cp_ready = 1'b0, cp_done = 1'b0;
  logic        st_ready = 1'b0, st_done = 1'b0, st_blk = 1'b0;
  logic [15:0] wdog_limit = 16'd0;
  logic        abort = 1'b0;
  logic        ap_done, ap_idle, ap_ready, ld_start, cp_start, st_start, hang;
  logic [1:0]  hang_phase;
  logic [31:0] frame_cnt;

  always #5 ap_clk = ~ap_clk;

  fft_phase_sequencer dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .ap_start   (ap_start),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .ap_ready   (ap_ready),
    .ld_start   (ld_start),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .ld_blk     (ld_blk),
    .cp_start   (cp_start),
    .cp_ready   (cp_ready),
    .cp_done    (cp_done),
    .st_start   (st_start),
    .st_ready   (st_ready),
    .st_done    (st_done),
    .st_blk     (st_blk),
    .wdog_limit (wdog_limit),
    .abort      (abort),
    .hang       (hang),
    .hang_phase (hang_phase),
    .frame_cnt  (frame_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 load, 2 comp, 3 store, 4 done, 5 hang.
  bit          m_valid = 0;
  int          m_ph = 0;
  bit          m_started = 0;
  int          m_run = 0;  // current run of consecutive blocked cycles
  logic [31:0] m_frames = 0;
  logic [1:0]  m_hph = 0;

  task automatic model_step();
    int rdy, dn, blkv, run;
    if (ap_rst) begin
      m_valid = 1; m_ph = 0; m_started = 0; m_run = 0; m_frames = 0; m_hph = 0;
      return;
    end
    if (!m_valid) return;
    case (m_ph)
      0: if (ap_start) begin m_ph = 1; m_started = 0; m_run = 0; end
      1, 2, 3: begin
        rdy  = (m_ph == 1) ? ld_ready : (m_ph == 2) ? cp_ready : st_ready;
        dn   = (m_ph == 1) ? ld_done  : (m_ph == 2) ? cp_done  : st_done;
        blkv = (m_ph == 1) ? ld_blk   : (m_ph == 3) ? st_blk   : 0;
        run  = blkv ? ((m_run + 1 > 65535) ? 65535 : m_run + 1) : 0;
        if (dn) begin
          m_ph = m_ph + 1; m_started = 0; m_run = 0;
        end else if (m_ph != 2 && wdog_limit != 0 && blkv && run >= wdog_limit) begin
          m_hph = (m_ph == 1) ? 2'b01 : 2'b10; m_ph = 5; m_run = 0;
        end else begin
          m_started = m_started | (rdy != 0); m_run = run;
        end
      end
      4: begin m_frames = m_frames + 1; m_ph = 0; end
      5: if (abort) begin m_ph = 0; m_hph = 0; end
      default: m_ph = 0;
    endcase
  endtask

  always @(negedge ap_clk) begin
    if (m_valid) begin
      check("ap_idle",    ap_idle,    m_ph == 0);
      check("ap_done",    ap_done,    m_ph == 4);
      check("ap_ready",   ap_ready,   m_ph == 4);
      check("ld_start",   ld_start,   m_ph == 1 && !m_started);
      check("cp_start",   cp_start,   m_ph == 2 && !m_started);
      check("st_start",   st_start,   m_ph == 3 && !m_started);
      check("hang",       hang,       m_ph == 5);
      check("hang_phase", hang_phase, m_hph);
      check("frame_cnt",  frame_cnt,  m_frames);
    end
    model_step();
  end

  // Sub-block responders, timed by cycles spent in the model's current phase.
  int cyc = 0, prev_ph = -1;
  int rdy_at[4], lat[4], blk_mode[4];
  bit rnd_lat = 0, st_done_force = 0;

  function automatic bit blk_val(input int mode, input int c);
    case (mode)
      1: return 1'b1;
      2: return ((c - 1) % 10) < 9;
      3: return 1'($urandom % 2);
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
    if (m_ph != prev_ph) begin
      cyc = 1;
      if (rnd_lat && m_ph >= 1 && m_ph <= 3) begin
        lat[m_ph]    = $urandom_range(1, 12);
        rdy_at[m_ph] = $urandom_range(1, lat[m_ph] + 2);
      end
    end else begin
      cyc++;
    end
    prev_ph  = m_ph;
    ld_ready = m_ph == 1 && cyc == rdy_at[1];
    ld_done  = m_ph == 1 && lat[1] != 0 && cyc == lat[1];
    ld_blk   = m_ph == 1 && blk_val(blk_mode[1], cyc);
    cp_ready = m_ph == 2 && cyc == rdy_at[2];
    cp_done  = m_ph == 2 && lat[2] != 0 && cyc == lat[2];
    st_ready = m_ph == 3 && cyc == rdy_at[3];
    st_done  = m_ph == 3 && (st_done_force || (lat[3] != 0 && cyc == lat[3]));
    st_blk   = m_ph == 3 && blk_val(blk_mode[3], cyc);
  endtask

  int n_ld, n_cp, n_st;
  bit got, hang_seen;

  initial begin
    rdy_at = '{0, 1, 1, 1}; lat = '{0, 32, 80, 32}; blk_mode = '{0, 0, 0, 0};
    repeat (3) tick();
    ap_rst = 1'b0;
    tick();
    check("rst_idle", ap_idle, 1); check("rst_fcnt", frame_cnt, 0);
    check("rst_hang", hang, 0);    check("rst_ld_start", ld_start, 0);

    // Nominal frame with ap_start held until ap_done.
    ap_start = 1'b1; n_ld = 0; n_cp = 0; n_st = 0; got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      n_ld += int'(ld_start); n_cp += int'(cp_start); n_st += int'(st_start);
      if (ap_done) begin got = 1; ap_start = 1'b0; check("nom_ready", ap_ready, 1); end
    end
    check("nom_done_seen", got, 1);
    check("nom_ld_width", n_ld, 1); check("nom_cp_width", n_cp, 1); check("nom_st_width", n_st, 1);
    tick();
    check("nom_fcnt", frame_cnt, 1); check("nom_idle", ap_idle, 1); check("nom_no_done", ap_done, 0);

    // COMP ready and done on its first cycle.
    lat = '{0, 3, 1, 4};
    ap_start = 1'b1; tick(); ap_start = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin tick(); got = cp_start; end
    check("rd_cp_start_seen", got, 1);
    tick();
    check("rd_st_start", st_start, 1); check("rd_cp_start_off", cp_start, 0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin tick(); got = ap_done; end
    check("rd_done_seen", got, 1);
    tick();
    check("rd_fcnt", frame_cnt, 2);

    // LOAD hang after 100 blocked cycles, then abort.
    wdog_limit = 16'd100; lat = '{0, 0, 80, 32}; blk_mode[1] = 1;
    ap_start = 1'b1; tick(); ap_start = 1'b0;
    check("lh_ld_start", ld_start, 1);
    repeat (99) tick();
    check("lh_no_hang_100", hang, 0);
    tick();
    check("lh_hang", hang, 1); check("lh_phase", hang_phase, 2'b01); check("lh_ld_off", ld_start, 0);
    ap_start = 1'b1; repeat (3) tick();
    check("lh_start_ignored", hang, 1);
    ap_start = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    check("lh_abort_hang", hang, 0); check("lh_abort_phase", hang_phase, 0);
    check("lh_abort_idle", ap_idle, 1); check("lh_abort_fcnt", frame_cnt, 2);
    blk_mode[1] = 0;

    // STORE blocked 9 of every 10 cycles, limit 10: no hang.
    wdog_limit = 16'd10; lat = '{0, 4, 4, 50}; blk_mode[3] = 2;
    ap_start = 1'b1; tick(); ap_start = 1'b0;
    got = 0; hang_seen = 0;
    for (int i = 0; i < 200 && !got; i++) begin tick(); hang_seen |= hang; got = ap_done; end
    check("nc_no_hang", hang_seen, 0); check("nc_done_seen", got, 1);
    tick();
    check("nc_fcnt", frame_cnt, 3);

    // Watchdog disabled for a long stall, then done beats the trip.
    wdog_limit = 16'd0; lat = '{0, 3, 3, 0}; blk_mode[3] = 1;
    ap_start = 1'b1; tick(); ap_start = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin tick(); got = st_start; end
    check("wd_st_seen", got, 1);
    hang_seen = 0;
    for (int i = 0; i < 70000; i++) begin tick(); hang_seen |= hang; end
    check("wd_disabled", hang_seen, 0);
    blk_mode[3] = 0; tick();
    wdog_limit = 16'd5; blk_mode[3] = 1;
    repeat (4) tick();
    st_done_force = 1; tick(); st_done_force = 0;
    tick();
    check("wd_prio_done", ap_done, 1); check("wd_prio_hang", hang, 0);
    blk_mode[3] = 0; tick();
    check("wd_fcnt", frame_cnt, 4);

    // Reset in the middle of COMP.
    wdog_limit = 16'd0; lat = '{0, 3, 0, 5};
    ap_start = 1'b1; tick(); ap_start = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin tick(); got = cp_start; end
    check("mr_cp_seen", got, 1);
    repeat (5) tick();
    ap_rst = 1'b1; tick();
    check("mr_ld", ld_start, 0); check("mr_cp", cp_start, 0); check("mr_st", st_start, 0);
    check("mr_idle", ap_idle, 1); check("mr_fcnt", frame_cnt, 0);
    ap_rst = 1'b0; lat = '{0, 3, 3, 3};
    ap_start = 1'b1; tick(); ap_start = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin tick(); got = ap_done; end
    check("mr_frame_done", got, 1);
    tick();
    check("mr_fcnt_after", frame_cnt, 1);

    // Randomized traffic, checked by the model every cycle.
    rnd_lat = 1; blk_mode = '{0, 3, 0, 3};
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) wdog_limit = 16'($urandom_range(0, 6));
      ap_start = ($urandom % 3) == 0;
      abort    = ($urandom % 6) == 0;
      ap_rst   = ($urandom % 400) == 0;
      tick();
    end
    ap_rst = 1'b0; ap_start = 1'b0; abort = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_phase_sequencer.md
Name: fft_phase_sequencer

Overview:
Top-level control FSM for the 32-point FFT kernel. It sequences three HLS sub-blocks under ap_ctrl_hs handshakes, one frame at a time: LOAD (input AXIS loop), COMP (butterfly stages) and STORE (output AXIS loop). It includes a stall watchdog that detects a sustained AXIS block in LOAD or STORE, latches a hang state and reports it, so a stuck stream is flagged in hardware as well as in simulation.

Parameters:
WDOG_W, 16, width of the stall counter and of the wdog_limit port
FCNT_W, 32, width of the completed-frame counter

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous reset, active high
ap_start  in  1  kernel start, ap_ctrl_hs level
ap_done  out  1  one-cycle pulse when a frame finishes STORE
ap_idle  out  1  high in IDLE
ap_ready  out  1  one-cycle pulse, coincident with ap_done
ld_start  out  1  LOAD sub-block ap_start
ld_ready  in  1  LOAD ap_ready
ld_done  in  1  LOAD ap_done
ld_blk  in  1  LOAD input stream blocked (inverted TDATA_blk_n)
cp_start  out  1  COMP ap_start
cp_ready  in  1  COMP ap_ready
cp_done  in  1  COMP ap_done
st_start  out  1  STORE ap_start
st_ready  in  1  STORE ap_ready
st_done  in  1  STORE ap_done
st_blk  in  1  STORE output stream blocked
wdog_limit  in  WDOG_W  stall threshold in cycles; 0 disables the watchdog
abort  in  1  leave HANG and return to IDLE
hang  out  1  high in HANG
hang_phase  out  2  phase that hung: 01 = LOAD, 10 = STORE, 00 = none
frame_cnt  out  FCNT_W  count of completed frames, wraps

Behaviour:
- Reset (ap_rst=1 at an ap_clk edge):
  - State goes to IDLE. This applies from any state, mid-frame included.
  - Outputs: all starts 0, ap_done 0, ap_ready 0, ap_idle 1, hang 0, hang_phase 00, frame_cnt 0, stall counter 0.
- States: IDLE, LOAD, COMP, STORE, DONE, HANG. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - ap_start=1 -> LOAD next cycle.
  - ap_start=0 -> stay in IDLE.
- Phase states (LOAD, COMP, STORE):
  - The phase start output is 1 from state entry until the first cycle the matching ready=1 is sampled.
  - It deasserts the cycle after ready is sampled. An internal started flag is cleared on entry to each phase.
  - done=1 -> advance to the next phase (LOAD->COMP->STORE->DONE).
  - done is honoured even if it arrives in the same cycle as ready, or before ready.
  - Minimum dwell per phase is 1 cycle.
- DONE: one cycle. ap_done=1, ap_ready=1, frame_cnt+1, then -> IDLE. frame_cnt wraps from all-ones to 0.
- Frame latency: start to ap_done is 4 + sum of the sub-block latencies, with back-to-back frames separated by at least one IDLE cycle.
- Watchdog (LOAD and STORE only):
  - The stall counter increments on each cycle with blk=1. It clears on any cycle with blk=0 and on every phase entry.
  - When the counter reaches wdog_limit (with blk still 1 that cycle): -> HANG. hang_phase is set to the phase that hung.
  - done=1 in the same cycle as the limit is reached takes priority: the FSM advances normally and does not hang.
  - wdog_limit=0: no HANG ever.
  - Counter saturates at all-ones; it never wraps.
  - Not active in COMP.
- HANG:
  - All starts 0, hang=1, hang_phase held. frame_cnt is not incremented.
  - abort=1 -> IDLE next cycle, clearing hang and hang_phase.
  - ap_start is ignored while in HANG.
- ap_rst always takes priority over abort and all other inputs.

Decomposition:
- Shared package fft_ctrl_pkg holds:
  - state enum (IDLE, LOAD, COMP, STORE, DONE, HANG)
  - hang_phase encodings (PH_NONE=00, PH_LOAD=01, PH_STORE=10)
  - default WDOG_W and FCNT_W
- One sub-module, fft_stall_watchdog. Inputs: enable, clear, blk, limit. Output: trip. It holds the saturating counter and compare, and is instantiated once with blk muxed by state.

Test Plan:
- Nominal frame: ap_start=1 held; ld/cp/st ready at 1 cycle and done at 32/80/32 cycles -> single ap_done pulse, frame_cnt=1, ap_idle returns to 1, each start is high for exactly 1 cycle.
- Ready and done in the same cycle: cp_ready=cp_done=1 on the first COMP cycle -> STORE entered the next cycle, cp_start high for 1 cycle only.
- Load hang: wdog_limit=100, ld_blk held 1 -> hang=1 and hang_phase=01 on the cycle after the 100th blocked cycle; abort pulse -> IDLE, hang=0, frame_cnt unchanged.
- Blocked cycles that are not consecutive: wdog_limit=10, st_blk pattern of 9 cycles on then 1 off, repeated 5 times, then st_done -> no HANG, frame completes.
- Watchdog disabled and done priority: wdog_limit=0 with st_blk=1 for 70000 cycles -> no HANG. Then wdog_limit=5 with st_done asserted on the trip cycle -> DONE, not HANG.
- Reset mid-COMP: assert ap_rst during COMP -> all starts 0, ap_idle=1, frame_cnt=0 next cycle; a subsequent ap_start runs a full frame.
